// File: rtl/potential_driver_8.sv
// potential_driver_8: per-neuron float spike accumulator and potential-update initiator.
// Sums weighted spikes per timestep, decays the potential and hands both to an external adder.
module potential_driver_8 #(
  parameter int unsigned DECAY_SHIFT = 1,
  parameter int unsigned ADDER_LAT   = 2,
  parameter logic [31:0] V_INIT      = 32'h00000000
) (
  input  logic        CLK_Driver8,
  input  logic        clear,
  input  logic        spike_in_valid,
  output logic        spike_in_ready,
  input  logic [31:0] weight_in,
  input  logic        timestep_end,
  output logic [31:0] input_weightDriver8,
  output logic [31:0] decayed_potentialDriver8,
  output logic        adder_busy,
  input  logic [31:0] final_potential_in,
  input  logic        spike_in_adder,
  output logic [31:0] potential_out,
  output logic        spike_out,
  output logic        spike_out_valid,
  output logic        timestep_overrun,
  output logic        acc_exception
);

  localparam logic [7:0] DSH = 8'(DECAY_SHIFT);
  localparam logic [3:0] LAT = 4'(ADDER_LAT);

  typedef enum logic [1:0] {ACCUM, DECAY, WAIT, CAPTURE} state_t;

  state_t      state, state_nxt;
  logic [31:0] acc;
  logic [3:0]  wait_cnt;
  logic [32:0] add_res;
  logic        capture;

  // m[26:3] significand, m[2] guard, m[1:0] round/sticky; round to nearest even
  function automatic logic [32:0] round_pack(input logic s, input logic [8:0] e,
                                             input logic [26:0] m);
    logic [24:0] rm;
    logic [8:0]  er;
    logic        up;
    er = e;
    up = m[2] & (m[1] | m[0] | m[3]);
    rm = {1'b0, m[26:3]} + {24'd0, up};
    if (rm[24]) begin
      rm = rm >> 1;
      er = er + 9'd1;
    end
    if (er >= 9'd255) return {1'b1, s, 8'hFF, 23'd0};
    if (!rm[23]) return {1'b0, s, 8'h00, rm[22:0]};
    return {1'b0, s, er[7:0], rm[22:0]};
  endfunction

  // Single-precision add; bit 32 flags a NaN result or overflow to infinity
  function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [8:0]  ex, ey, d, er;
    logic [26:0] bx, by, tmp;
    logic [27:0] sum;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
          (a[30:0] == b[30:0] && a[31] != b[31]))
        return {1'b1, 32'h7FC00000};
      return {1'b0, (a[30:23] == 8'hFF) ? a : b};
    end
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    ex  = (x[30:23] == 8'd0) ? 9'd1 : {1'b0, x[30:23]};
    ey  = (y[30:23] == 8'd0) ? 9'd1 : {1'b0, y[30:23]};
    bx  = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    tmp = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d   = ex - ey;
    if (d >= 9'd27) begin
      by = {26'd0, |tmp};
    end else begin
      by = tmp >> d;
      if ((by << d) != tmp) by[0] = 1'b1;
    end
    if (x[31] == y[31]) sum = {1'b0, bx} + {1'b0, by};
    else                sum = {1'b0, bx} - {1'b0, by};
    er = ex;
    if (sum == 28'd0) return {1'b0, x[31] & y[31], 31'd0};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      er  = er + 9'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26] && er > 9'd1) begin
          sum = sum << 1;
          er  = er - 9'd1;
        end
      end
    end
    return round_pack(x[31], er, sum[26:0]);
  endfunction

  // Halve by exponent decrement; small magnitudes flush to +0, inf/NaN pass through
  function automatic logic [31:0] decay(input logic [31:0] v);
    if (v[30:23] == 8'hFF) return v;
    if (v[30:23] <= DSH) return 32'h00000000;
    return {v[31], v[30:23] - DSH, v[22:0]};
  endfunction

  assign add_res = fadd(acc, weight_in);
  assign capture = (state == WAIT) && (wait_cnt == 4'd1);

  always_ff @(posedge CLK_Driver8 or posedge clear) begin
    if (clear) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (timestep_end) state_nxt = DECAY;
      DECAY:   state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    spike_in_ready = (state == ACCUM);
  end

  // The adder result is taken on the edge leaving WAIT so spike_out_valid is high during CAPTURE
  always_ff @(posedge CLK_Driver8 or posedge clear) begin
    if (clear) begin
      acc                      <= 32'h00000000;
      wait_cnt                 <= 4'd0;
      input_weightDriver8      <= 32'h00000000;
      decayed_potentialDriver8 <= 32'h00000000;
      adder_busy               <= 1'b0;
      potential_out            <= V_INIT;
      spike_out                <= 1'b0;
      spike_out_valid          <= 1'b0;
      timestep_overrun         <= 1'b0;
      acc_exception            <= 1'b0;
    end else begin
      spike_out_valid <= 1'b0;
      if (timestep_end && state != ACCUM) timestep_overrun <= 1'b1;
      case (state)
        ACCUM: begin
          if (spike_in_valid) begin
            acc <= add_res[31:0];
            if (add_res[32]) acc_exception <= 1'b1;
          end
        end
        DECAY: begin
          input_weightDriver8      <= acc;
          decayed_potentialDriver8 <= decay(potential_out);
          wait_cnt                 <= LAT;
          adder_busy               <= 1'b1;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (capture) begin
            potential_out   <= final_potential_in;
            spike_out       <= spike_in_adder;
            spike_out_valid <= 1'b1;
            acc             <= 32'h00000000;
            adder_busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/potential_driver_8.md
Name: potential_driver_8

Overview:
- Initiator side of the per-neuron potential-update interface.
- Accepts incoming weighted spike events during a timestep and accumulates their IEEE-754 single-precision weights.
- At timestep end it decays the stored membrane potential, presents accumulated weight plus decayed potential to a combinational potential adder, then captures the adder's final potential and spike flag back into its state.
- One instance per neuron, sitting between the spike router and potential_adder_8-class adders.

Parameters:
- DECAY_SHIFT, 1, decay factor is 2^-DECAY_SHIFT, applied by exponent decrement (1..31).
- ADDER_LAT, 2, cycles the adder outputs are given to settle before capture (1..15).
- V_INIT, 32'h00000000, membrane potential value loaded on reset.

Ports:
- CLK_Driver8  in  1  clock; all state updates on rising edge
- clear  in  1  asynchronous, active-high reset
- spike_in_valid  in  1  weighted spike event present
- spike_in_ready  out  1  driver accepts events (high only in ACCUM)
- weight_in  in  32  float weight of event
- timestep_end  in  1  single-cycle pulse closing the timestep
- input_weightDriver8  out  32  accumulated weight to adder
- decayed_potentialDriver8  out  32  decayed potential to adder
- adder_busy  out  1  high while adder operands are driven and awaited
- final_potential_in  in  32  adder result
- spike_in_adder  in  1  adder spike flag
- potential_out  out  32  current membrane potential register
- spike_out  out  1  spike result of last timestep
- spike_out_valid  out  1  one-cycle pulse when spike_out/potential_out update
- timestep_overrun  out  1  sticky: timestep_end arrived outside ACCUM
- acc_exception  out  1  sticky: float adder exception during accumulation

Behaviour:
- Reset (clear high, asynchronous): state=ACCUM, accumulator=0, potential_out=V_INIT, adder operand outputs=0, adder_busy=0, spike_out=0, spike_out_valid=0, both sticky flags=0, wait counter=0. Reset mid-operation aborts; the in-flight result is discarded.
- FSM states: ACCUM, DECAY, WAIT, CAPTURE.
- ACCUM:
  - spike_in_ready=1.
  - On valid&&ready: acc <= acc + weight_in through the codebase float Addition_Subtraction (op=add), one event per cycle, no back-pressure latency.
  - Adder exception sets acc_exception.
  - timestep_end -> DECAY. If a spike is accepted in the same cycle, it is included in this timestep's accumulation.
- DECAY (1 cycle):
  - spike_in_ready=0.
  - input_weightDriver8 <= acc.
  - decayed_potentialDriver8 <= decay(potential_out).
  - Wait counter loads ADDER_LAT.
  - adder_busy <= 1.
  - Next state WAIT.
- decay(v):
  - sign preserved.
  - exp==255 (inf/NaN): passes unchanged.
  - exp <= DECAY_SHIFT (includes zero and denormals): result +0 (32'h00000000).
  - Otherwise exp - DECAY_SHIFT, mantissa unchanged.
- WAIT: counter decrements each cycle; at counter==1 -> CAPTURE. Operands are held constant throughout.
- CAPTURE (1 cycle):
  - potential_out <= final_potential_in.
  - spike_out <= spike_in_adder.
  - spike_out_valid <= 1 for exactly one cycle.
  - acc <= 0.
  - adder_busy <= 0.
  - Next state ACCUM.
- Latency: timestep_end sampled at edge E0. Operands are valid after E1. Adder result is sampled at edge E(1+ADDER_LAT). spike_out_valid is high in the cycle following that edge.
- Spike events while not in ACCUM are not accepted (ready=0). The source holds them.
- timestep_end while not in ACCUM: ignored, timestep_overrun set.
- Sticky flags clear only on reset.
- Operand outputs retain last values between timesteps.

Test Plan:
- Reset, V_INIT=0; three events weight 32'h3F800000, then timestep_end -> input_weightDriver8=32'h40400000 (3.0), decayed_potentialDriver8=0.
- potential_out=32'h41200000 (10.0), DECAY_SHIFT=1, timestep_end with no events -> decayed_potentialDriver8=32'h40A00000 (5.0), input weight 0.
- Model adder returns 32'h3F000000 with spike=1, ADDER_LAT=2 -> spike_out_valid pulses 3 edges after the timestep_end edge; spike_out=1, potential_out=32'h3F000000; acc reads 0 next timestep.
- Denormal/underflow: potential 32'h00800000, DECAY_SHIFT=1 -> decayed operand 32'h00000000; potential 32'h7F800000 -> passed unchanged.
- Event 32'h40000000 coincident with timestep_end -> included (input weight 2.0); a second timestep_end during WAIT -> ignored, timestep_overrun=1, single spike_out_valid.
- Assert clear during WAIT -> all outputs at reset values immediately, no spike_out_valid, spike_in_ready=1 after release.
